// File: rtl/sqrt_arbiter_pkg.sv
// Shared types, constants and the single-precision square-root helper used
// by the sqrt_arbiter slice.
//   SQRT_LATENCY : operand-in to result-out latency of the sqrt pipeline
//   MAX_NREQ     : largest requester count the tag width can address
//   sqrt_tag_t   : requester index carried alongside each operand
//   tag_stage_t  : one stage of the tag pipe {valid, tag}
package sqrt_arb_pkg;

    localparam int SQRT_LATENCY = 5;
    localparam int MAX_NREQ     = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef logic [2:0] sqrt_tag_t;

    typedef struct packed {
        logic      v;
        sqrt_tag_t tag;
    } tag_stage_t;

    // Digit-by-digit integer square root of a 50-bit radicand (25-bit root).
    function automatic logic [24:0] isqrt50(input logic [49:0] rad);
        logic [27:0] rem;
        logic [27:0] trial;
        logic [24:0] root;
        rem  = 28'h0;
        root = 25'h0;
        for (int i = 24; i >= 0; i--) begin
            rem   = {rem[25:0], rad[2*i +: 2]};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[23:0], 1'b1};
            end else begin
                root = {root[23:0], 1'b0};
            end
        end
        return root;
    endfunction

    // IEEE single square root, round to nearest. Subnormals flush to signed
    // zero; negative non-zero operands and NaNs give the canonical quiet NaN.
    function automatic logic [31:0] sqrt_f32(input logic [31:0] a);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [49:0] rad;
        logic [24:0] r;
        logic [8:0]  esum;
        logic [31:0] res;
        s    = a[31];
        e    = a[30:23];
        f    = a[22:0];
        rad  = 50'h0;
        r    = 25'h0;
        esum = 9'h0;
        if (e == 8'hFF) begin
            res = ((f != 23'h0) || s) ? QNAN : a;
        end else if (e == 8'h00) begin
            res = {s, 31'h0};
        end else if (s) begin
            res = QNAN;
        end else begin
            // An even unbiased exponent (odd biased) needs no pre-shift; an
            // odd one folds one factor of two into the mantissa.
            rad  = e[0] ? {1'b0, 1'b1, f, 25'h0} : {1'b1, f, 26'h0};
            r    = isqrt50(rad);
            esum = {1'b0, e} + 9'd126 + {8'h0, e[0]};
            // r[0] is the guard bit; square roots never land on a tie, and a
            // rounding carry ripples naturally into the exponent field.
            res  = {1'b0, esum[8:1], r[23:1]} + {31'h0, r[0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Requester-side bundle of sqrt_arbiter.
//   req_valid/req_x/req_ready : issue handshake, one operand slot per requester
//   resp_valid/resp_y         : one-cycle response pulse and shared result
//   busy                      : operations in flight
// master = requester side, slave = arbiter side.
interface sqrt_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_y;
    logic               busy;

    modport master (
        output req_valid, req_x,
        input  req_ready, resp_valid, resp_y, busy
    );

    modport slave (
        input  req_valid, req_x,
        output req_ready, resp_valid, resp_y, busy
    );
endinterface

// File: rtl/sqrt_arbiter_sqrt.sv
// Fully pipelined single-precision square root (module sqrt).
//   clk, rstn : clock, asynchronous active-low reset
//   x         : operand, IEEE single
//   y         : sqrt(x), valid LATENCY cycles after x was presented
// The result is formed in front of the first register; the remaining stages
// only delay it, so one operand can enter every cycle.
module sqrt
    import sqrt_arb_pkg::*;
#(
    parameter int LATENCY = SQRT_LATENCY
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] root_s;
    logic [31:0] stage_r [LATENCY];

    // Combinational square root of the incoming operand.
    always_comb begin
        root_s = sqrt_f32(x);
    end

    // Result delay line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= 32'h0;
            end
        end else begin
            stage_r[0] <= root_s;
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign y = stage_r[LATENCY-1];

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined sqrt unit among NREQ requesters.
//   clk, rstn : clock, asynchronous active-low reset (also resets the sqrt)
//   bus       : sqrt_arbiter_if.slave -- req_valid/req_x/req_ready issue
//               handshake, resp_valid/resp_y responses, busy
//   perf_sel, perf_cnt : per-requester issue counter readback, present only
//               when SQRT_ARB_PERF_EN is defined
// A {valid, tag} pipe runs in lock-step with the sqrt so each result is
// steered back to the requester that issued it, LATENCY cycles later.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = SQRT_LATENCY
) (
    input  logic                    clk,
    input  logic                    rstn,
    sqrt_arbiter_if.slave           bus
`ifdef SQRT_ARB_PERF_EN
    ,
    input  logic [$clog2(NREQ)-1:0] perf_sel,
    output logic [31:0]             perf_cnt
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] gnt_idx_s;
    logic [PW-1:0] cand_s;
    int            cand_int;
    logic          take_s;
    logic          found_s;
    logic          handshake_s;
    logic [31:0]   x_s;
    logic [31:0]   y_s;
    tag_stage_t    pipe_r [LATENCY];
    logic [NREQ-1:0] resp_valid_s;
    logic          busy_s;

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = '0;
        cand_int  = 0;
        cand_s    = '0;
        take_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_int  = int'(rr_ptr_r) + k;
            cand_int  = (cand_int >= NREQ) ? cand_int - NREQ : cand_int;
            cand_s    = PW'(cand_int);
            take_s    = !found_s && bus.req_valid[cand_s];
            gnt_idx_s = take_s ? cand_s : gnt_idx_s;
            found_s   = found_s | take_s;
        end
    end

    // Grant is suppressed while reset is asserted so nothing is accepted.
    assign handshake_s   = found_s && rstn;
    assign bus.req_ready = handshake_s ? (ONE_HOT0 << gnt_idx_s) : '0;

    // Operand mux into the sqrt; zero when nothing is granted.
    always_comb begin
        x_s = 32'h0;
        for (int i = 0; i < NREQ; i++) begin
            x_s = (handshake_s && (gnt_idx_s == PW'(i))) ? bus.req_x[32*i +: 32] : x_s;
        end
    end

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_r <= '0;
        end else if (handshake_s) begin
            rr_ptr_r <= (gnt_idx_s == PW'(NREQ-1)) ? '0 : gnt_idx_s + PW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag pipe, same depth as the sqrt so the last stage matches sqrt.y.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_r[s] <= '{v: 1'b0, tag: 3'd0};
            end
        end else begin
            pipe_r[0] <= '{v: handshake_s, tag: sqrt_tag_t'(gnt_idx_s)};
            for (int s = 1; s < LATENCY; s++) begin
                pipe_r[s] <= pipe_r[s-1];
            end
        end
    end

    // Response steering and in-flight indication from the tag pipe.
    always_comb begin
        resp_valid_s = '0;
        busy_s       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid_s[i] = pipe_r[LATENCY-1].v && (pipe_r[LATENCY-1].tag == sqrt_tag_t'(i));
        end
        for (int s = 0; s < LATENCY; s++) begin
            busy_s = busy_s | pipe_r[s].v;
        end
    end

    assign bus.resp_valid = resp_valid_s;
    assign bus.busy       = busy_s;
    assign bus.resp_y     = y_s;

    sqrt #(
        .LATENCY (LATENCY)
    ) u_sqrt (
        .clk  (clk),
        .rstn (rstn),
        .x    (x_s),
        .y    (y_s)
    );

`ifdef SQRT_ARB_PERF_EN
    logic [31:0] issue_cnt_r [NREQ];
    logic [31:0] perf_cnt_r;

    // Per-requester issue counters (wrap at 2^32) and registered readback.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                issue_cnt_r[i] <= 32'h0;
            end
            perf_cnt_r <= 32'h0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                issue_cnt_r[i] <= (handshake_s && (gnt_idx_s == PW'(i))) ?
                                  issue_cnt_r[i] + 32'd1 : issue_cnt_r[i];
            end
            perf_cnt_r <= issue_cnt_r[perf_sel];
        end
    end

    assign perf_cnt = perf_cnt_r;
`endif

endmodule
